i_mem_fill_ctrl: RTL and testbench

- Miss-fill engine between the instruction cache's registered miss request and the single-port, 32-bit-wide instruction memory.
- On each accepted fill request it issues four word reads, assembles one 128-bit cache line, and returns it with a one-cycle valid pulse.
- The response fields are held stable so the cache can latch them in its fill state.

---
 rtl/i_mem_fill_ctrl.sv | 120 ++++++++++++
 tb/tb_i_mem_fill_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_fill_ctrl.sv
// Instruction-cache miss-fill engine: four 32-bit reads assembled into one 128-bit line.
// Optional critical-word-first issue order when IFU_FILL_CWF_EN is defined.
module i_mem_fill_ctrl #(
  parameter int MEM_RD_LATENCY = 1,
  parameter int CL_WIDTH       = 128,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_req_valid,
  input  logic [ADDR_WIDTH-1:0] fill_req_address,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_address,
  output logic [CL_WIDTH-1:0]   rsp_filled_instruction,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESPOND} state_t;

  state_t                              state, state_next;
  logic [ADDR_WIDTH-1:0]               req_addr;
  logic [1:0]                          start_idx;
  logic [1:0]                          issue_idx;
  logic [2:0]                          iss_cnt;
  logic [2:0]                          rcv_cnt;
  logic [2:0]                          rcv_next;
  logic                                accept;
  logic [MEM_RD_LATENCY-1:0]           pipe_vld;
  logic [MEM_RD_LATENCY-1:0][1:0]      pipe_idx;
  logic                                cap;
  logic [1:0]                          cap_idx;

  // DRAIN looks at the count including this cycle's capture so RESPOND follows the last word directly.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    rsp_valid   = 1'b0;
    busy        = (state != IDLE);
    issue_idx   = start_idx + iss_cnt[1:0];
    cap         = pipe_vld[MEM_RD_LATENCY-1];
    cap_idx     = pipe_idx[MEM_RD_LATENCY-1];
    rcv_next    = (cap && (rcv_cnt != 3'd4)) ? rcv_cnt + 3'd1 : rcv_cnt;

    case (state)
      IDLE: begin
        if (fill_req_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = {req_addr[ADDR_WIDTH-1:4], issue_idx, 2'b00};
        if (iss_cnt == 3'd3) begin
          state_next = (rcv_next == 3'd4) ? RESPOND : DRAIN;
        end
      end
      DRAIN: begin
        if (rcv_next == 3'd4) begin
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      req_addr               <= '0;
      start_idx              <= 2'd0;
      iss_cnt                <= 3'd0;
      rcv_cnt                <= 3'd0;
      pipe_vld               <= '0;
      pipe_idx               <= '0;
      rsp_address            <= '0;
      rsp_filled_instruction <= '0;
    end else begin
      state       <= state_next;
      pipe_vld[0] <= mem_rd_en;
      pipe_idx[0] <= issue_idx;
      for (int i = 1; i < MEM_RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end

      if (accept) begin
        req_addr <= fill_req_address;
`ifdef IFU_FILL_CWF_EN
        start_idx <= fill_req_address[3:2];
`else
        start_idx <= 2'd0;
`endif
        iss_cnt  <= 3'd0;
        rcv_cnt  <= 3'd0;
      end else begin
        if (mem_rd_en && (iss_cnt != 3'd4)) begin
          iss_cnt <= iss_cnt + 3'd1;
        end
        rcv_cnt <= rcv_next;
      end

      // Response fields only change once the next fill actually returns data.
      if (cap) begin
        rsp_filled_instruction[{cap_idx, 5'b00000} +: 32] <= mem_rd_data;
        rsp_address <= req_addr;
      end
    end
  end

endmodule

// File: tb/tb_i_mem_fill_ctrl.sv
// Self-checking bench for i_mem_fill_ctrl: one DUT at read latency 1 and one at latency 3.
// Expected issue order follows IFU_FILL_CWF_EN when the bench is built with it defined.
module tb_i_mem_fill_ctrl;

  localparam int NCYC = 24;

  logic         clk = 1'b0;
  logic         rst_s            [2];
  logic         req_v            [2];
  logic [31:0]  req_a            [2];
  logic         mem_rd_en        [2];
  logic [31:0]  mem_rd_addr      [2];
  logic [31:0]  mem_rd_data      [2];
  logic         rsp_valid        [2];
  logic [31:0]  rsp_address      [2];
  logic [127:0] rsp_line         [2];
  logic         busy             [2];

  logic [31:0]  salt;
  int           checks   = 0;
  int           failures = 0;

  logic         obs_en   [NCYC];
  logic [31:0]  obs_addr [NCYC];
  logic         obs_busy [NCYC];
  logic         obs_rv   [NCYC];
  logic [31:0]  obs_raddr[NCYC];
  logic [127:0] obs_line [NCYC];

  always #5 clk = ~clk;

  // Memory contents: the 0x123x line is a fixed pattern, everything else a salted hash.
  function automatic logic [31:0] mem_val(input logic [31:0] addr);
    if (addr[31:4] == 28'h0000123) return 32'hA0 + {30'b0, addr[3:2]};
    return (addr * 32'h9E3779B1) ^ salt;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [L-1:0]       qv;
    logic [L-1:0][31:0] qd;
    logic [31:0]        garbage;

    i_mem_fill_ctrl #(.MEM_RD_LATENCY(L)) dut (
      .clk                    (clk),
      .rst                    (rst_s[g]),
      .fill_req_valid         (req_v[g]),
      .fill_req_address       (req_a[g]),
      .mem_rd_en              (mem_rd_en[g]),
      .mem_rd_addr            (mem_rd_addr[g]),
      .mem_rd_data            (mem_rd_data[g]),
      .rsp_valid              (rsp_valid[g]),
      .rsp_address            (rsp_address[g]),
      .rsp_filled_instruction (rsp_line[g]),
      .busy                   (busy[g])
    );

    always @(posedge clk) begin
      qv[0] <= mem_rd_en[g];
      qd[0] <= mem_val(mem_rd_addr[g]);
      for (int i = 1; i < L; i++) begin
        qv[i] <= qv[i-1];
        qd[i] <= qd[i-1];
      end
      garbage <= $urandom;
    end
    assign mem_rd_data[g] = qv[L-1] ? qd[L-1] : garbage;
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] start_word(input logic [31:0] a);
`ifdef IFU_FILL_CWF_EN
    return a[3:2];
`else
    return 2'd0;
`endif
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] a);
    logic [127:0] l;
    for (int j = 0; j < 4; j++) l[32*j +: 32] = mem_val({a[31:4], 4'b0} + 32'(4 * j));
    return l;
  endfunction

  // Drives a request at cycle 0 and records outputs for cycles 0..n; optional extra request / reset.
  task automatic run_fill(input int d, input logic [31:0] a, input int n,
                          input int inj_c, input logic [31:0] inj_a, input int rst_c);
    @(negedge clk);
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clk);
      obs_en[c]    = mem_rd_en[d];
      obs_addr[c]  = mem_rd_addr[d];
      obs_busy[c]  = busy[d];
      obs_rv[c]    = rsp_valid[d];
      obs_raddr[c] = rsp_address[d];
      obs_line[c]  = rsp_line[d];
      req_v[d]     = (c == 0) || (c == inj_c);
      req_a[d]     = (c == inj_c) ? inj_a : a;
      rst_s[d]     = (c == rst_c);
    end
  endtask

  task automatic test_reset();
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    req_a[0] = '0;   req_a[1] = '0;
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks += 1;
      if ({busy[d], mem_rd_en[d], rsp_valid[d]} !== 3'b000) begin
        failures += 1;
        $display("[TB] FAIL reset_ctrl d=%0d got=%b exp=000", d, {busy[d], mem_rd_en[d], rsp_valid[d]});
      end
      checks += 1;
      if (mem_rd_addr[d] !== 32'h0 || rsp_address[d] !== 32'h0) begin
        failures += 1;
        $display("[TB] FAIL reset_addr d=%0d got=%h/%h exp=0", d, mem_rd_addr[d], rsp_address[d]);
      end
      checks += 1;
      if (rsp_line[d] !== 128'h0) begin
        failures += 1;
        $display("[TB] FAIL reset_line d=%0d got=%h exp=0", d, rsp_line[d]);
      end
    end
  endtask

  // Full cycle-by-cycle check of one isolated fill.
  task automatic test_single_fill(input int d, input logic [31:0] a);
    int L, n;
    logic [31:0] exp_a;
    L = lat(d);
    n = 8 + L;
    run_fill(d, a, n, -1, 32'h0, -1);
    for (int c = 0; c <= n; c++) begin
      checks += 1;
      if (obs_en[c] !== (c >= 1 && c <= 4)) begin
        failures += 1;
        $display("[TB] FAIL fill_en d=%0d a=%h c=%0d got=%b exp=%b", d, a, c, obs_en[c], (c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        exp_a = {a[31:4], 4'b0} + {28'b0, 2'(start_word(a) + 2'(c - 1)), 2'b00};
        checks += 1;
        if (obs_addr[c] !== exp_a) begin
          failures += 1;
          $display("[TB] FAIL fill_addr d=%0d c=%0d got=%h exp=%h", d, c, obs_addr[c], exp_a);
        end
      end
      checks += 1;
      if (obs_busy[c] !== (c >= 1 && c <= 5 + L)) begin
        failures += 1;
        $display("[TB] FAIL fill_busy d=%0d c=%0d got=%b exp=%b", d, c, obs_busy[c], (c >= 1 && c <= 5 + L));
      end
      checks += 1;
      if (obs_rv[c] !== (c == 5 + L)) begin
        failures += 1;
        $display("[TB] FAIL fill_rsp_valid d=%0d c=%0d got=%b exp=%b", d, c, obs_rv[c], (c == 5 + L));
      end
    end
    checks += 1;
    if (obs_raddr[5+L] !== a || obs_line[5+L] !== exp_line(a)) begin
      failures += 1;
      $display("[TB] FAIL fill_rsp d=%0d got=%h/%h exp=%h/%h", d, obs_raddr[5+L], obs_line[5+L], a, exp_line(a));
    end
  endtask

  task automatic test_basic();
    for (int d = 0; d < 2; d++) begin
      test_single_fill(d, 32'h0000_1234);
      checks += 1;
      if (obs_line[5+lat(d)] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
        failures += 1;
        $display("[TB] FAIL basic_line d=%0d got=%h exp=A3A2A1A0", d, obs_line[5+lat(d)]);
      end
    end
  endtask

  task automatic test_random_fills();
    for (int k = 0; k < 6; k++) begin
      salt = $urandom;
      test_single_fill(k % 2, $urandom);
    end
  endtask

  task automatic test_back_to_back(input int d);
    int L;
    logic [31:0]  old_a;
    logic [127:0] old_l;
    L = lat(d);
    run_fill(d, 32'h0000_1234, 6 + L, -1, 32'h0, -1);
    old_a = obs_raddr[5+L];
    old_l = obs_line[5+L];
    checks += 1;
    if (obs_rv[5+L] !== 1'b1 || old_l !== exp_line(32'h1234)) begin
      failures += 1;
      $display("[TB] FAIL b2b_first d=%0d got=%b/%h exp=1/%h", d, obs_rv[5+L], old_l, exp_line(32'h1234));
    end
    run_fill(d, 32'h0000_2000, 8 + L, -1, 32'h0, -1);
    for (int c = 1; c <= 4; c++) begin
      checks += 1;
      if (obs_en[c] !== 1'b1 || obs_addr[c] !== 32'h2000 + 32'(4 * (c - 1))) begin
        failures += 1;
        $display("[TB] FAIL b2b_addr d=%0d c=%0d got=%b/%h exp=1/%h", d, c, obs_en[c], obs_addr[c], 32'h2000 + 32'(4 * (c - 1)));
      end
    end
    for (int c = 0; c <= 1 + L; c++) begin
      checks += 1;
      if (obs_raddr[c] !== old_a || obs_line[c] !== old_l) begin
        failures += 1;
        $display("[TB] FAIL b2b_hold d=%0d c=%0d got=%h/%h exp=%h/%h", d, c, obs_raddr[c], obs_line[c], old_a, old_l);
      end
    end
    checks += 1;
    if (obs_rv[5+L] !== 1'b1 || obs_raddr[5+L] !== 32'h2000 || obs_line[5+L] !== exp_line(32'h2000)) begin
      failures += 1;
      $display("[TB] FAIL b2b_second d=%0d got=%b/%h/%h exp=1/2000/%h", d, obs_rv[5+L], obs_raddr[5+L], obs_line[5+L], exp_line(32'h2000));
    end
  endtask

  task automatic test_busy_ignore(input int d);
    int L, n, rv_cnt;
    L = lat(d);
    n = 12 + L;
    run_fill(d, 32'h0000_1230, n, 2, 32'h0000_3000, -1);
    rv_cnt = 0;
    for (int c = 0; c <= n; c++) begin
      if (obs_rv[c] === 1'b1) rv_cnt += 1;
      checks += 1;
      if (obs_en[c] !== (c >= 1 && c <= 4) || (obs_en[c] === 1'b1 && obs_addr[c][31:4] !== 28'h0000123)) begin
        failures += 1;
        $display("[TB] FAIL ignore_issue d=%0d c=%0d got=%b/%h exp_en=%b", d, c, obs_en[c], obs_addr[c], (c >= 1 && c <= 4));
      end
    end
    checks += 1;
    if (rv_cnt != 1 || obs_rv[5+L] !== 1'b1) begin
      failures += 1;
      $display("[TB] FAIL ignore_rsp_count d=%0d got=%0d exp=1", d, rv_cnt);
    end
    checks += 1;
    if (obs_raddr[5+L] !== 32'h1230 || obs_line[5+L] !== exp_line(32'h1230)) begin
      failures += 1;
      $display("[TB] FAIL ignore_rsp d=%0d got=%h/%h exp=1230/%h", d, obs_raddr[5+L], obs_line[5+L], exp_line(32'h1230));
    end
  endtask

  task automatic test_reset_mid_fill(input int d);
    run_fill(d, 32'h0000_1230, 4, -1, 32'h0, 3);
    checks += 1;
    if (obs_en[3] !== 1'b1) begin
      failures += 1;
      $display("[TB] FAIL midrst_pre d=%0d got=%b exp=1", d, obs_en[3]);
    end
    checks += 1;
    if ({obs_busy[4], obs_en[4], obs_rv[4]} !== 3'b000) begin
      failures += 1;
      $display("[TB] FAIL midrst_idle d=%0d got=%b exp=000", d, {obs_busy[4], obs_en[4], obs_rv[4]});
    end
    salt = $urandom;
    test_single_fill(d, 32'h0000_4A5C);
  endtask

  task automatic test_cwf();
    for (int d = 0; d < 2; d++) test_single_fill(d, 32'h0000_0038);
  endtask

  initial begin
    salt = $urandom;
    test_reset();
    test_basic();
    test_random_fills();
    test_back_to_back(0);
    test_back_to_back(1);
    test_busy_ignore(0);
    test_busy_ignore(1);
    test_reset_mid_fill(0);
    test_reset_mid_fill(1);
    test_cwf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
